// File: rtl/cp0_irq_ctrl.sv
// Interrupt aggregator feeding cp0: edge-detect, pend, mask, priority-select, one request in flight.
// Latency: src rise -> ir_in 2 edges (4 edges with CP0_IRQ_SYNC_EN defined: 2-flop src synchroniser).
// Backpressure: after a request, no further ir_in until cp0 pulses eret; events keep pending meanwhile.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   src[N_SRC]          raw interrupt lines, rising edge = event
//   mask_we, mask_wdata mask register write (1 = source enabled)
//   eret                handler-return pulse from cp0
//   ir_in               registered one-cycle request pulse
//   irq_id              id of requested/serviced source, held until next request
//   busy                high while a request is outstanding (REQ or SERVICE)
//   pending, mask       register copies
//
// Optional build macro: CP0_IRQ_SYNC_EN (adds a 2-flop synchroniser on every src bit).

module cp0_irq_ctrl #(
  parameter int               N_SRC    = 4,
  parameter logic [N_SRC-1:0] MASK_RST = {N_SRC{1'b1}}
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_SRC-1:0] src,
  input  logic             mask_we,
  input  logic [N_SRC-1:0] mask_wdata,
  input  logic             eret,
  output logic             ir_in,
  output logic [3:0]       irq_id,
  output logic             busy,
  output logic [N_SRC-1:0] pending,
  output logic [N_SRC-1:0] mask
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    SERVICE = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [N_SRC-1:0] src_s;
  logic [N_SRC-1:0] src_q;
  logic [N_SRC-1:0] rise;
  logic [N_SRC-1:0] eligible;
  logic [N_SRC-1:0] win_oh;
  logic [3:0]       win_id;
  logic             grant;

`ifdef CP0_IRQ_SYNC_EN
  logic [N_SRC-1:0] sync1;
  logic [N_SRC-1:0] sync2;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= src;
      sync2 <= sync1;
    end
  end

  assign src_s = sync2;
`else
  assign src_s = src;
`endif

  // Edge history clears on reset, so a line already high afterwards is one event.
  always_ff @(posedge clk) begin
    if (rst) begin
      src_q <= '0;
    end else begin
      src_q <= src_s;
    end
  end

  assign rise     = src_s & ~src_q;
  assign eligible = pending & mask;

  // Lowest index wins: scan downward so the last hit is the lowest set bit.
  always_comb begin
    win_id = '0;
    win_oh = '0;
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (eligible[i]) begin
        win_id    = 4'(i);
        win_oh    = '0;
        win_oh[i] = 1'b1;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    grant     = 1'b0;
    case (state)
      IDLE: begin
        if (|eligible) begin
          state_nxt = REQ;
          grant     = 1'b1;
        end
      end
      REQ: begin
        state_nxt = eret ? IDLE : SERVICE;
      end
      SERVICE: begin
        if (eret) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      ir_in   <= 1'b0;
      irq_id  <= '0;
      pending <= '0;
      mask    <= MASK_RST;
    end else begin
      state <= state_nxt;
      // ir_in is high exactly for the cycle spent in REQ.
      ir_in <= grant;
      if (grant) begin
        irq_id <= win_id;
      end
      // A new rise on the winner in the grant cycle wins over the clear.
      pending <= (pending & ~(grant ? win_oh : '0)) | rise;
      if (mask_we) begin
        mask <= mask_wdata;
      end
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_cp0_irq_ctrl.sv
// Self-checking bench for cp0_irq_ctrl: directed scenarios plus randomized traffic vs a reference model.
// Latency: each step is one clock; outputs compared 1 time unit after the rising edge.
// Backpressure: eret is issued by the bench only as stimulus; the model tracks outstanding requests.

module tb_cp0_irq_ctrl;

  localparam int N = 4;
`ifdef CP0_IRQ_SYNC_EN
  localparam int SX = 2;
`else
  localparam int SX = 0;
`endif

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic [N-1:0] src = '0;
  logic         mask_we = 1'b0;
  logic [N-1:0] mask_wdata = '0;
  logic         eret = 1'b0;
  logic         ir_in;
  logic [3:0]   irq_id;
  logic         busy;
  logic [N-1:0] pending;
  logic [N-1:0] mask;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state: a bitset of pending events, the mask, whether a
  // request is outstanding, and the raw-line history used for edge detection.
  int m_pend = 0;
  int m_mask = 15;
  int m_prev = 0;
  int m_h1   = 0;
  int m_h2   = 0;
  int m_out  = 0;
  int m_ir   = 0;
  int m_id   = 0;

  cp0_irq_ctrl #(.N_SRC(N), .MASK_RST(4'b1111)) dut (
    .clk        (clk),
    .rst        (rst),
    .src        (src),
    .mask_we    (mask_we),
    .mask_wdata (mask_wdata),
    .eret       (eret),
    .ir_in      (ir_in),
    .irq_id     (irq_id),
    .busy       (busy),
    .pending    (pending),
    .mask       (mask)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Advance the model by one clock using the inputs present at that edge.
  task automatic model_edge();
    int s;
    int rs;
    int elig;
    int w;
    bit found;
    if (rst) begin
      m_pend = 0; m_mask = 15; m_prev = 0; m_h1 = 0; m_h2 = 0;
      m_out = 0; m_ir = 0; m_id = 0;
    end else begin
      s     = (SX != 0) ? m_h2 : int'(src);
      rs    = s & ~m_prev;
      elig  = m_pend & m_mask;
      found = 0;
      w     = 0;
      if (m_out == 0) begin
        for (int i = 0; i < N; i++) begin
          if (!found && ((elig >> i) & 1) == 1) begin
            found = 1;
            w     = i;
          end
        end
      end
      if (found) m_pend = m_pend & ~(1 << w);
      m_pend = m_pend | rs;
      if (found) begin
        m_out = 1;
        m_id  = w;
      end else if (m_out == 1 && eret) begin
        m_out = 0;
      end
      m_ir = found ? 1 : 0;
      if (mask_we) m_mask = int'(mask_wdata);
      m_prev = s;
      m_h2   = m_h1;
      m_h1   = int'(src);
    end
  endtask

  task automatic step(input logic [N-1:0] s, input logic we, input logic [N-1:0] wd,
                      input logic er, input logic r);
    src        = s;
    mask_we    = we;
    mask_wdata = wd;
    eret       = er;
    rst        = r;
    @(posedge clk);
    model_edge();
    #1;
    check("model_ir_in",   ir_in,   m_ir);
    check("model_irq_id",  irq_id,  m_id);
    check("model_busy",    busy,    m_out);
    check("model_pending", pending, m_pend);
    check("model_mask",    mask,    m_mask);
  endtask

  task automatic st(input logic [N-1:0] s);
    step(s, 1'b0, '0, 1'b0, 1'b0);
  endtask

  // One rising event on v, held until it has reached the pending register.
  task automatic apply_event(input logic [N-1:0] v);
    st(v);
    repeat (SX) st(v);
  endtask

  initial begin
    logic [N-1:0] s;
    logic         we;
    logic         er;
    logic         r;

    // 1: reset with all lines high, then each line counts as one event.
    step(4'hf, 1'b0, '0, 1'b0, 1'b1);
    step(4'hf, 1'b0, '0, 1'b0, 1'b1);
    check("rst_ir_in", ir_in, 0);
    check("rst_pending", pending, 0);
    check("rst_mask", mask, 4'hf);
    check("rst_busy", busy, 0);
    check("rst_irq_id", irq_id, 0);
    repeat (SX + 1) st(4'hf);
    check("post_rst_pending", pending, 4'hf);
    check("post_rst_ir_in", ir_in, 0);
    step(4'h0, 1'b0, '0, 1'b0, 1'b1);
    st(4'h0);

    // 2: single event on src[2].
    apply_event(4'b0100);
    check("single_pend", pending, 4'b0100);
    check("single_no_ir", ir_in, 0);
    st(4'b0100);
    check("single_ir", ir_in, 1);
    check("single_id", irq_id, 2);
    check("single_pend_clr", pending, 0);
    check("single_busy", busy, 1);
    st(4'b0100);
    check("single_ir_once", ir_in, 0);
    check("single_busy_hold", busy, 1);
    step(4'b0100, 1'b0, '0, 1'b1, 1'b0);
    check("single_eret_idle", busy, 0);

    // 3: simultaneous rise on 3 and 1 -> 1 first, 3 only after eret.
    apply_event(4'b1010);
    check("prio_pend", pending, 4'b1010);
    st(4'b1010);
    check("prio_ir", ir_in, 1);
    check("prio_id", irq_id, 1);
    check("prio_pend_left", pending, 4'b1000);
    repeat (3) begin
      st(4'b1010);
      check("prio_holdoff", ir_in, 0);
      check("prio_busy", busy, 1);
    end
    step(4'b1010, 1'b0, '0, 1'b1, 1'b0);
    check("prio_eret_ir", ir_in, 0);
    check("prio_eret_busy", busy, 0);
    st(4'b1010);
    check("prio_second_ir", ir_in, 1);
    check("prio_second_id", irq_id, 3);
    step(4'b1010, 1'b0, '0, 1'b1, 1'b0);
    check("prio_eret_in_req", busy, 0);
    st(4'b1010);
    check("prio_quiet", ir_in, 0);

    // 4: masked source pends but is not requested until unmasked.
    step(4'b0000, 1'b1, 4'b1110, 1'b0, 1'b0);
    check("mask_written", mask, 4'b1110);
    apply_event(4'b0001);
    check("mask_pend", pending, 4'b0001);
    st(4'b0001);
    check("mask_blocks", ir_in, 0);
    check("mask_pend_kept", pending, 4'b0001);
    step(4'b0001, 1'b1, 4'b1111, 1'b0, 1'b0);
    check("mask_old_used", ir_in, 0);
    st(4'b0001);
    check("unmask_ir", ir_in, 1);
    check("unmask_id", irq_id, 0);
    step(4'b0001, 1'b0, '0, 1'b1, 1'b0);

    // 5: new rise on src[0] in the same edge pending[0] is taken.
    step(4'b0000, 1'b1, 4'b1110, 1'b0, 1'b0);
    repeat (SX + 1) st(4'b0000);
    apply_event(4'b0001);
    repeat (SX + 1) st(4'b0000);
    check("coll_pend_pre", pending, 4'b0001);
    check("coll_idle", busy, 0);
    repeat (SX) st(4'b0001);
    step((SX != 0) ? 4'b0001 : 4'b0000, 1'b1, 4'b1111, 1'b0, 1'b0);
    check("coll_no_ir_yet", ir_in, 0);
    st(4'b0001);
    check("coll_ir", ir_in, 1);
    check("coll_id", irq_id, 0);
    check("coll_pend_stays", pending, 4'b0001);
    step(4'b0001, 1'b0, '0, 1'b1, 1'b0);
    check("coll_eret", busy, 0);
    st(4'b0001);
    check("coll_ir2", ir_in, 1);
    check("coll_id2", irq_id, 0);
    check("coll_pend_clr", pending, 0);
    step(4'b0001, 1'b0, '0, 1'b1, 1'b0);

    // 6: reset while in service with a pending event.
    repeat (SX + 2) st(4'b0000);
    apply_event(4'b0110);
    st(4'b0110);
    check("mid_ir", ir_in, 1);
    check("mid_id", irq_id, 1);
    st(4'b0110);
    check("mid_service_busy", busy, 1);
    check("mid_service_pend", pending, 4'b0100);
    step(4'b0000, 1'b0, '0, 1'b0, 1'b1);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_pend", pending, 0);
    check("mid_rst_ir", ir_in, 0);
    repeat (4) begin
      st(4'b0000);
      check("mid_rst_quiet", ir_in, 0);
    end

    // Randomized traffic, checked every cycle against the model.
    s = '0;
    for (int k = 0; k < 4000; k++) begin
      for (int b = 0; b < N; b++) begin
        if ($urandom_range(0, 5) == 0) s[b] = ~s[b];
      end
      we = ($urandom_range(0, 15) == 0);
      er = (m_out == 1) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 15) == 0);
      r  = ($urandom_range(0, 299) == 0);
      step(s, we, 4'($urandom), er, r);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
